// File: rtl/queue_fifo.sv
// Single-clock FIFO queue with registered read data and full/empty flags.
// Depth is 2**PTR_SIZE. Occupancy is kept in a count one bit wider than the pointers.
module queue_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int PTR_SIZE  = 2
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic                 wr_req,
    input  logic                 r_req,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 1 << PTR_SIZE;
    localparam logic [PTR_SIZE:0] COUNT_FULL = (PTR_SIZE+1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_SIZE-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_SIZE-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_SIZE:0]    count_q, count_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 wrEn;
    logic                 rdEn;

    // Flags come from registered state only, so no input reaches an output combinationally.
    assign empty  = (count_q == '0);
    assign full   = (count_q == COUNT_FULL);
    assign data_o = data_q;

    assign wrEn = wr_req && !full;
    assign rdEn = r_req && !empty;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        data_d  = data_q;
        if (wrEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdEn) begin
            rdPtr_d = rdPtr_q + 1'b1;
            data_d  = mem_q[rdPtr_q];
        end
        case ({wrEn, rdEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    // Storage is never cleared; reset just blocks the write so the pointers define validity.
    always_ff @(posedge clk) begin
        if (a_rst && wrEn) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_queue_fifo.sv
// Self-checking bench for queue_fifo (DATA_SIZE=4, PTR_SIZE=2) using a queue model
// and a scoreboard of expected read data.
module tb_queue_fifo;

    localparam int DW    = 4;
    localparam int PW    = 2;
    localparam int DEPTH = 1 << PW;

    logic          clk;
    logic          a_rst;
    logic          wr_req;
    logic          r_req;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          full;
    logic          empty;

    int checkCount = 0;
    int passCount  = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] lastData = '0;

    queue_fifo #(.DATA_SIZE(DW), .PTR_SIZE(PW)) dut (
        .clk    (clk),
        .a_rst  (a_rst),
        .wr_req (wr_req),
        .r_req  (r_req),
        .data_i (data_i),
        .data_o (data_o),
        .full   (full),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".empty"}, 32'(empty), 32'(model.size() == 0));
        checkOutput({tag, ".full"},  32'(full),  32'(model.size() == DEPTH));
        checkOutput({tag, ".data"},  32'(data_o), 32'(lastData));
    endtask

    // One clock cycle of normal operation; the model is updated from pre-edge occupancy.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [DW-1:0] din, input string tag);
        bit acceptRd;
        bit acceptWr;
        @(negedge clk);
        a_rst  = 1'b1;
        wr_req = wr;
        r_req  = rd;
        data_i = din;
        acceptRd = rd && (model.size() != 0);
        acceptWr = wr && (model.size() != DEPTH);
        @(posedge clk);
        if (acceptRd) expQ.push_back(model.pop_front());
        if (acceptWr) model.push_back(din);
        #1;
        if (expQ.size() != 0) lastData = expQ.pop_front();
        checkAll(tag);
    endtask

    task automatic applyReset(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            a_rst  = 1'b0;
            wr_req = 1'b1;
            r_req  = 1'b0;
            data_i = 4'hA;
            @(posedge clk);
            model.delete();
            expQ.delete();
            lastData = '0;
            #1;
            checkAll(tag);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        a_rst  = 1'b0;
        wr_req = 1'b0;
        r_req  = 1'b0;
        data_i = '0;

        applyReset(2, "reset");
        applyStimulus(0, 0, 0, "postReset");

        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 4'(i), "fill");
        applyStimulus(1, 0, 4'h5, "writeFull");

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, "drain");
        applyStimulus(0, 1, 0, "readEmpty");

        applyStimulus(1, 1, 4'h7, "bothEmpty");
        applyStimulus(1, 1, 4'h8, "bothOne");
        for (int i = 9; i <= 11; i++) applyStimulus(1, 0, 4'(i), "refill");
        applyStimulus(1, 1, 4'hF, "bothFull");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, "drainAfterBoth");

        for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 4'(i), "wrapWrite");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, "wrapRead");
        for (int i = 9; i <= 12; i++) applyStimulus(1, 0, 4'(i), "wrapFill");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, "wrapDrain");

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), "random");
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, "randomDrain");

        applyStimulus(1, 0, 4'h3, "preReset");
        applyStimulus(1, 0, 4'h6, "preReset");
        applyStimulus(0, 1, 0, "preResetRead");
        applyReset(1, "midReset");
        applyStimulus(0, 1, 0, "readAfterReset");
        applyStimulus(1, 0, 4'hD, "writeAfterReset");
        applyStimulus(0, 1, 0, "readAfterResetWrite");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
